matrix_kxk_window: RTL

- Parametrised KxK sliding-window generator for the conv pipeline, successor to the fixed 3-row line-buffer tap block.
- Accepts a raster pixel stream (left to right, top to bottom) with per-pixel valid and start-of-frame.
- Emits one registered, fully populated KSIZE x KSIZE window per accepted pixel once the window lies entirely inside the frame.
- Also emits the window-centre coordinates, an end-of-frame marker and a start-of-frame misalignment error.

---
 rtl/matrix_kxk_window.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/matrix_kxk_window.sv
// KxK sliding-window generator for a raster pixel stream.
// KSIZE-1 cascaded line buffers feed a KSIZE x KSIZE shift array. A window
// is emitted, registered, one cycle after each accepted pixel whose window
// lies entirely inside the frame. Frame position is tracked by col/row
// counters that restart on sof_in or on reset.
module matrix_kxk_window #(
    parameter int WIDTH   = 10,
    parameter int COL_NUM = 480,
    parameter int ROW_NUM = 272,
    parameter int KSIZE   = 3,
    parameter int CW      = $clog2(COL_NUM),
    parameter int RW      = $clog2(ROW_NUM)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          valid_in,
    input  logic                          sof_in,
    input  logic [WIDTH-1:0]              din,
    output logic                          win_valid,
    output logic [KSIZE*KSIZE*WIDTH-1:0]  win,
    output logic [RW-1:0]                 win_row,
    output logic [CW-1:0]                 win_col,
    output logic                          win_eof,
    output logic                          err_sof
);

    localparam int NL = KSIZE - 1;
    localparam logic [CW-1:0] LAST_C = CW'(COL_NUM - 1);
    localparam logic [RW-1:0] LAST_R = RW'(ROW_NUM - 1);
    localparam logic [CW-1:0] KM1_C  = CW'(KSIZE - 1);
    localparam logic [RW-1:0] KM1_R  = RW'(KSIZE - 1);
    localparam logic [CW-1:0] HALF_C = CW'(KSIZE / 2);
    localparam logic [RW-1:0] HALF_R = RW'(KSIZE / 2);

    // Position counters: coordinates of the next pixel to be accepted.
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    // Coordinates of the pixel presented this cycle (sof forces (0,0)).
    logic [CW-1:0] cur_col;
    logic [RW-1:0] cur_row;
    logic          accept;
    logic          emit;
    logic          at_last;

    // Line buffer taps and column feeding the shift array.
    logic [WIDTH-1:0] lb_in  [NL];
    logic [WIDTH-1:0] lb_out [NL];
    logic [WIDTH-1:0] col_in [KSIZE];

    // Shift array, row 0 oldest, column 0 leftmost.
    logic [WIDTH-1:0] sh_q [KSIZE][KSIZE];
    logic [WIDTH-1:0] sh_d [KSIZE][KSIZE];
    logic [KSIZE*KSIZE*WIDTH-1:0] win_d;

    // Registered outputs.
    logic                         win_valid_q;
    logic                         win_eof_q;
    logic                         err_sof_q;
    logic [KSIZE*KSIZE*WIDTH-1:0] win_q;
    logic [RW-1:0]                win_row_q;
    logic [CW-1:0]                win_col_q;

    // A pixel is taken only when no reset is pending; reset drops it.
    assign accept  = valid_in && !rst;
    assign cur_col = sof_in ? '0 : col_q;
    assign cur_row = sof_in ? '0 : row_q;
    assign emit    = accept && (cur_row >= KM1_R) && (cur_col >= KM1_C);
    assign at_last = (cur_row == LAST_R) && (cur_col == LAST_C);

    // Cascaded line buffers: line k returns the pixel k+1 rows above.
    genvar gi, gj;
    generate
        for (gi = 0; gi < NL; gi++) begin : g_line
            logic [WIDTH-1:0] lb_mem [COL_NUM];

            if (gi == 0) begin : g_first
                assign lb_in[gi] = din;
            end else begin : g_next
                assign lb_in[gi] = lb_out[gi-1];
            end

            assign lb_out[gi] = lb_mem[cur_col];

            // Read-before-write at the current column pushes the row down one line.
            always_ff @(posedge clk) begin
                if (accept) begin
                    lb_mem[cur_col] <= lb_in[gi];
                end
            end
        end
    endgenerate

    // Newest row comes straight from din, older rows from the line buffers.
    generate
        for (gi = 0; gi < KSIZE; gi++) begin : g_col
            if (gi == KSIZE - 1) begin : g_new
                assign col_in[gi] = din;
            end else begin : g_old
                assign col_in[gi] = lb_out[KSIZE-2-gi];
            end
        end
    endgenerate

    // Next shift-array contents: shift left, new column enters on the right.
    generate
        for (gi = 0; gi < KSIZE; gi++) begin : g_row
            for (gj = 0; gj < KSIZE; gj++) begin : g_tap
                if (gj == KSIZE - 1) begin : g_in
                    assign sh_d[gi][gj] = col_in[gi];
                end else begin : g_shift
                    assign sh_d[gi][gj] = sh_q[gi][gj+1];
                end
                assign win_d[(gi*KSIZE+gj)*WIDTH +: WIDTH] = sh_d[gi][gj];
            end
        end
    endgenerate

    // Shift array advances only on accepted pixels.
    always_ff @(posedge clk) begin
        if (accept) begin
            sh_q <= sh_d;
        end
    end

    // Counter advance with column and row wrap.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (valid_in) begin
            if (cur_col == LAST_C) begin
                col_d = '0;
                row_d = (cur_row == LAST_R) ? '0 : cur_row + 1'b1;
            end else begin
                col_d = cur_col + 1'b1;
                row_d = cur_row;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // Output registers: strobes every cycle, window data held between windows.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_valid_q <= 1'b0;
            win_eof_q   <= 1'b0;
            err_sof_q   <= 1'b0;
            win_q       <= '0;
            win_row_q   <= '0;
            win_col_q   <= '0;
        end else begin
            win_valid_q <= emit;
            win_eof_q   <= emit && at_last;
            err_sof_q   <= valid_in && sof_in && ((row_q != '0) || (col_q != '0));
            if (emit) begin
                win_q     <= win_d;
                win_row_q <= cur_row - HALF_R;
                win_col_q <= cur_col - HALF_C;
            end
        end
    end

    assign win_valid = win_valid_q;
    assign win_eof   = win_eof_q;
    assign err_sof   = err_sof_q;
    assign win       = win_q;
    assign win_row   = win_row_q;
    assign win_col   = win_col_q;

endmodule
